// File: rtl/mcu_ctrl.sv
// Three-cycle fetch/decode/execute sequencer for a small accumulator MCU.
// Drives program-memory address, ALU opcode/mux select and one-cycle RAM/W strobes.
module mcu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [10:0] rom_addr,
    input  logic [13:0] rom_q,
    output logic [3:0]  op,
    output logic        sel_lit,
    output logic [7:0]  literal,
    output logic [6:0]  ram_addr,
    output logic        ram_we,
    output logic        ram_wsrc,
    output logic        load_w,
    output logic        busy,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DECODE  = 2'd2,
        S_EXEC_WB = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_PASS = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_ZERO = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;

    typedef struct packed {
        logic [3:0] op;
        logic       sel_lit;
        logic       ram_we;
        logic       ram_wsrc;
        logic       load_w;
        logic       jump;
    } ctl_t;

    // Anything not matched below falls through as a NOP (ALU pass, no strobes).
    function automatic ctl_t decode(input logic [13:0] ir);
        ctl_t c;
        logic is_file;
        c.op       = OP_PASS;
        c.sel_lit  = 1'b0;
        c.ram_we   = 1'b0;
        c.ram_wsrc = 1'b0;
        c.load_w   = 1'b0;
        c.jump     = 1'b0;
        is_file    = 1'b0;
        if (ir[13:11] == 3'b101) begin
            c.jump = 1'b1;
        end else begin
            case (ir[13:8])
                6'h30: begin c.op = OP_PASS; c.sel_lit = 1'b1; c.load_w = 1'b1; end
                6'h3E: begin c.op = OP_ADD;  c.sel_lit = 1'b1; c.load_w = 1'b1; end
                6'h3C: begin c.op = OP_SUB;  c.sel_lit = 1'b1; c.load_w = 1'b1; end
                6'h39: begin c.op = OP_AND;  c.sel_lit = 1'b1; c.load_w = 1'b1; end
                6'h38: begin c.op = OP_OR;   c.sel_lit = 1'b1; c.load_w = 1'b1; end
                6'h3A: begin c.op = OP_XOR;  c.sel_lit = 1'b1; c.load_w = 1'b1; end
                6'h07: begin c.op = OP_ADD;  is_file = 1'b1; end
                6'h02: begin c.op = OP_SUB;  is_file = 1'b1; end
                6'h05: begin c.op = OP_AND;  is_file = 1'b1; end
                6'h04: begin c.op = OP_OR;   is_file = 1'b1; end
                6'h06: begin c.op = OP_XOR;  is_file = 1'b1; end
                6'h08: begin c.op = OP_PASS; is_file = 1'b1; end
                6'h0A: begin c.op = OP_INC;  is_file = 1'b1; end
                6'h03: begin c.op = OP_DEC;  is_file = 1'b1; end
                6'h09: begin c.op = OP_NOT;  is_file = 1'b1; end
                6'h01: begin
                    c.op = OP_ZERO;
                    if (ir[7]) c.ram_we = 1'b1;
                    else       c.load_w = 1'b1;
                end
                6'h00: begin
                    if (ir[7]) begin c.ram_we = 1'b1; c.ram_wsrc = 1'b1; end
                end
                default: ;
            endcase
            // File ops: d=1 writes the ALU result back to RAM, d=0 loads W.
            if (is_file) begin
                if (ir[7]) c.ram_we = 1'b1;
                else       c.load_w = 1'b1;
            end
        end
        return c;
    endfunction

    state_t      r_state;
    logic [10:0] r_pc;
    logic [13:0] r_ir;
    logic        r_ram_we;
    logic        r_load_w;

    ctl_t w_next;
    ctl_t w_cur;

    assign w_next = decode(rom_q);
    assign w_cur  = decode(r_ir);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= 11'd0;
            r_ir     <= 14'd0;
            r_ram_we <= 1'b0;
            r_load_w <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so they can only pulse for one clock.
            r_ram_we <= 1'b0;
            r_load_w <= 1'b0;
            case (r_state)
                S_IDLE:   if (run) r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_ir     <= rom_q;
                    r_pc     <= r_pc + 11'd1;
                    r_ram_we <= w_next.ram_we;
                    r_load_w <= w_next.load_w;
                    r_state  <= S_EXEC_WB;
                end
                S_EXEC_WB: begin
                    if (w_cur.jump) r_pc <= r_ir[10:0];
                    r_state <= run ? S_FETCH : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr = r_pc;
    assign op       = w_cur.op;
    assign sel_lit  = w_cur.sel_lit;
    assign ram_wsrc = w_cur.ram_wsrc;
    assign literal  = r_ir[7:0];
    assign ram_addr = r_ir[6:0];
    assign ram_we   = r_ram_we;
    assign load_w   = r_load_w;
    assign busy     = (r_state != S_IDLE);
    assign state    = r_state;

endmodule

// File: tb/tb_mcu_ctrl.sv
// Directed bench for mcu_ctrl: synchronous ROM model plus hand-computed control vectors.
module tb_mcu_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic [10:0] rom_addr;
    logic [13:0] rom_q;
    logic [3:0]  op;
    logic        sel_lit;
    logic [7:0]  literal;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic        ram_wsrc;
    logic        load_w;
    logic        busy;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [13:0] rom [2048];

    mcu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .op       (op),
        .sel_lit  (sel_lit),
        .literal  (literal),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wsrc (ram_wsrc),
        .load_w   (load_w),
        .busy     (busy),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Program for the decode sweep; expected = {op, sel_lit, ram_we, ram_wsrc, load_w},
    // op nibble F means op/sel_lit are don't-care for that instruction.
    localparam int NPROG = 19;
    logic [13:0] prog [NPROG] = '{
        14'h3E12, 14'h3C12, 14'h3912, 14'h3812, 14'h3A12,
        14'h0285, 14'h0505, 14'h0485, 14'h0605, 14'h0885,
        14'h0A05, 14'h0385, 14'h0905, 14'h0180, 14'h0100,
        14'h00A3, 14'h0000, 14'h3FFF, 14'h2FFF
    };
    logic [7:0] exp_ctl [NPROG] = '{
        8'h09, 8'h19, 8'h29, 8'h39, 8'h49,
        8'h14, 8'h21, 8'h34, 8'h41, 8'h54,
        8'h61, 8'h74, 8'h91, 8'h84, 8'h81,
        8'hF6, 8'h50, 8'h50, 8'hF0
    };

    initial begin
        logic [7:0]  got_ctl;
        logic [13:0] w;
        int          n_lw;
        int          n_we;
        int          n_both;

        for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
        rom[0] = 14'h3055;
        rom[1] = 14'h07A0;
        rom[2] = 14'h2800;
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_state",  {30'd0, state}, 32'd0);
        check("rst_addr",   {21'd0, rom_addr}, 32'd0);
        check("rst_strobe", {30'd0, ram_we, load_w}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_op",     {28'd0, op}, 32'd5);
        check("rst_fields", {16'd0, sel_lit, literal, ram_addr},
              {16'd0, 1'b0, 8'd0, 7'd0});
        check("rst_wsrc",   {31'd0, ram_wsrc}, 32'd0);

        // MOVLW / ADDWF / GOTO 0 loop
        reset = 1'b0;
        run   = 1'b1;
        @(negedge clk);
        check("fetch0", {18'd0, state, rom_addr, busy}, {18'd0, 2'd1, 11'd0, 1'b1});
        @(negedge clk);
        check("decode0", {28'd0, state, ram_we, load_w}, {28'd0, 2'd2, 2'b00});
        @(negedge clk);
        check("movlw", {4'd0, state, op, sel_lit, literal, load_w, ram_we, rom_addr},
              {4'd0, 2'd3, 4'd5, 1'b1, 8'h55, 1'b1, 1'b0, 11'd1});
        @(negedge clk);
        check("fetch1", {18'd0, state, load_w, rom_addr}, {18'd0, 2'd1, 1'b0, 11'd1});
        @(negedge clk);
        @(negedge clk);
        check("addwf", {18'd0, op, sel_lit, ram_addr, ram_we, ram_wsrc, load_w},
              {18'd0, 4'd0, 1'b0, 7'h20, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        check("fetch2", {19'd0, state, rom_addr}, {19'd0, 2'd1, 11'd2});
        @(negedge clk);
        @(negedge clk);
        check("goto_exec", {28'd0, state, ram_we, load_w}, {28'd0, 2'd3, 2'b00});
        @(negedge clk);
        check("goto_fetch", {19'd0, state, rom_addr}, {19'd0, 2'd1, 11'd0});

        n_lw = 0; n_we = 0; n_both = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (load_w) n_lw++;
            if (ram_we) n_we++;
            if (load_w && ram_we) n_both++;
        end
        check("loop_fetch", {19'd0, state, rom_addr}, {19'd0, 2'd1, 11'd0});
        check("loop_strobes", {n_lw[7:0], n_we[7:0], n_both[7:0]}, {8'd1, 8'd1, 8'd0});

        // Decode sweep, then GOTO 0x7FF and pc wrap
        reset = 1'b1;
        for (int i = 0; i < NPROG; i++) rom[i] = prog[i];
        rom[11'h7FF] = 14'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NPROG; i++) begin
            w = prog[i];
            @(negedge clk);
            check($sformatf("fetch_%0d", i), {17'd0, state, rom_addr, ram_we, load_w},
                  {17'd0, 2'd1, i[10:0], 2'b00});
            @(negedge clk);
            check($sformatf("decode_%0d", i), {28'd0, state, ram_we, load_w},
                  {28'd0, 2'd2, 2'b00});
            @(negedge clk);
            got_ctl = {op, sel_lit, ram_we, ram_wsrc, load_w};
            if (exp_ctl[i][7:4] == 4'hF) got_ctl[7:3] = exp_ctl[i][7:3];
            check($sformatf("ctl_%0h", w), {22'd0, state, got_ctl}, {22'd0, 2'd3, exp_ctl[i]});
            check($sformatf("fld_%0h", w), {6'd0, literal, ram_addr, rom_addr},
                  {6'd0, w[7:0], w[6:0], 11'(i + 1)});
        end
        @(negedge clk);
        check("fetch_7ff", {19'd0, state, rom_addr}, {19'd0, 2'd1, 11'h7FF});
        @(negedge clk);
        @(negedge clk);
        check("nop_7ff", {17'd0, state, ram_we, load_w, rom_addr}, {17'd0, 2'd3, 2'b00, 11'd0});
        @(negedge clk);
        check("wrap_fetch", {19'd0, state, rom_addr}, {19'd0, 2'd1, 11'd0});

        // Drop run mid-instruction (ADDLW at 0)
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("drop_exec", {28'd0, state, load_w, ram_we}, {28'd0, 2'd3, 2'b10});
        @(negedge clk);
        check("drop_idle", {28'd0, state, busy, load_w}, {28'd0, 2'd0, 2'b00});
        repeat (2) @(negedge clk);
        check("idle_hold", {19'd0, state, rom_addr}, {19'd0, 2'd0, 11'd1});
        rom[1] = 14'h0090;
        run = 1'b1;
        @(negedge clk);
        check("resume_fetch", {19'd0, state, rom_addr}, {19'd0, 2'd1, 11'd1});

        // Reset during EXEC_WB of MOVWF 0x10
        @(negedge clk);
        @(negedge clk);
        check("movwf", {22'd0, state, ram_we, ram_wsrc, load_w, ram_addr},
              {22'd0, 2'd3, 1'b1, 1'b1, 1'b0, 7'h10});
        reset = 1'b1;
        @(negedge clk);
        check("rst_exec", {12'd0, ram_we, load_w, state, rom_addr, busy, op},
              {12'd0, 1'b0, 1'b0, 2'd0, 11'd0, 1'b0, 4'd5});
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_fetch", {17'd0, state, ram_we, load_w, rom_addr},
              {17'd0, 2'd1, 2'b00, 11'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_ctrl.md
MCU_CTRL -- requirements
Module: mcu_ctrl

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high on port reset.
REQ-002 SHALL have ports, one per line (name direction width meaning):
 clk  in  1  clock, all state on rising edge
 reset  in  1  sync active-high reset
 run  in  1  1 = execute instructions; 0 = park in IDLE at next instruction boundary
 rom_addr  out  11  program memory address (= pc)
 rom_q  in  14  program word; synchronous ROM, valid 1 cycle after rom_addr
 op  out  4  ALU opcode (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 pass, 6 inc, 7 dec, 8 zero, 9 not)
 sel_lit  out  1  ALU mux1 source: 1 = literal, 0 = RAM read data
 literal  out  8  ir[7:0]
 ram_addr  out  7  ir[6:0]
 ram_we  out  1  one-cycle RAM write strobe
 ram_wsrc  out  1  RAM write data source: 1 = W, 0 = ALU result
 load_w  out  1  one-cycle W register load from ALU result
 busy  out  1  1 in any state except IDLE
 state  out  2  debug: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC_WB

Function
REQ-003 SHALL implement FSM IDLE -> FETCH -> DECODE -> EXEC_WB -> (FETCH if run else IDLE); IDLE -> FETCH when run=1, else stays in IDLE.
REQ-004 SHALL sample run only in IDLE and at the end of EXEC_WB; run dropping mid-instruction SHALL NOT abort it.
REQ-005 SHALL drive rom_addr = pc combinationally in all states.
REQ-006 In DECODE SHALL latch ir <= rom_q and set pc <= pc + 1, 11-bit wrap (0x7FF -> 0x000).
REQ-007 SHALL decode ir in EXEC_WB; op, sel_lit, literal, ram_addr, ram_wsrc SHALL derive from ir and stay stable from EXEC_WB until the next DECODE.
REQ-008 Literal ops (sel_lit=1, load_w=1 in EXEC_WB): MOVLW ir[13:8]=0x30 op5; ADDLW 0x3E op0; SUBLW 0x3C op1 (k-W); ANDLW 0x39 op2; IORLW 0x38 op3; XORLW 0x3A op4.
REQ-009 File ops (sel_lit=0; d=ir[7]; d=1 -> ram_we=1, ram_wsrc=0; d=0 -> load_w=1): ADDWF ir[13:8]=0x07 op0; SUBWF 0x02 op1; ANDWF 0x05 op2; IORWF 0x04 op3; XORWF 0x06 op4; MOVF 0x08 op5; INCF 0x0A op6; DECF 0x03 op7; COMF 0x09 op9.
REQ-010 CLRF (ir[13:7]=0x03) SHALL give op8, ram_we=1, ram_wsrc=0; CLRW (ir[13:7]=0x02) SHALL give op8, load_w=1.
REQ-011 MOVWF (ir[13:7]=0x01) SHALL give ram_we=1, ram_wsrc=1, load_w=0.
REQ-012 GOTO (ir[13:11]=3'b101) SHALL load pc <= ir[10:0] at the end of EXEC_WB, with no ram_we/load_w.
REQ-013 Any other encoding (incl. 0x0000) SHALL execute as NOP: op5, sel_lit=0, no strobes, pc unchanged in EXEC_WB.
REQ-014 ram_we and load_w SHALL be asserted only in EXEC_WB, exactly one cycle per instruction, never both in one cycle.
REQ-015 Each instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXEC_WB); back-to-back with run=1 gives 1 instruction per 3 clk.
REQ-016 In IDLE, FETCH and DECODE SHALL drive ram_we=0, load_w=0.

Reset
REQ-017 reset=1 at a rising edge SHALL set state IDLE, pc 0x000, ir 0x0000 and outputs: rom_addr 0, ram_we 0, load_w 0, busy 0, state 0, op 5, sel_lit 0, literal 0, ram_addr 0, ram_wsrc 0.
REQ-018 reset SHALL override run and any state, including mid-EXEC_WB; no strobe SHALL be issued in the reset cycle or the cycle after.
REQ-019 After reset release with run=1, first FETCH SHALL occur in the first cycle after reset release and read address 0.

Verification
REQ-020 ROM[0]=0x3055 (MOVLW 0x55), run=1 -> 3rd cycle after FETCH: op5, sel_lit1, literal 0x55, load_w=1 one cycle; pc=1.
REQ-021 ROM[1]=0x07A0 (ADDWF 0x20,d=1) -> EXEC_WB: op0, sel_lit0, ram_addr 0x20, ram_we=1, ram_wsrc0, load_w0.
REQ-022 ROM[2]=0x2800 (GOTO 0) -> no strobes, next FETCH rom_addr=0x000; loop repeats every 9 cycles.
REQ-023 pc=0x7FF with NOP -> next FETCH rom_addr 0x000.
REQ-024 run dropped during DECODE -> instruction completes with its strobe, then IDLE, busy=0; run re-raised -> FETCH at next pc.
REQ-025 reset asserted in EXEC_WB of MOVWF 0x0090 -> ram_we=0 in that cycle's output after edge, state 0, rom_addr 0.
